// File: rtl/mmcm_rst_ctrl.sv
// Purpose : MMCM reset sequencer; pulses MMCM RST, waits for stable lock, then releases system reset.
// Latency : lock rise -> rst_out fall = LOCK_SYNC_STAGES+1+RELEASE_DELAY_CYCLES edges; lock loss -> rst_out = LOCK_SYNC_STAGES+1.
// Backpress: none; free-running control block with no handshake.
//
// Ports:
//   clk_in        free-running reference clock (independent of MMCM outputs)
//   rst_in        asynchronous active-high reset
//   mmcm_lock     MMCM LOCKED, asynchronous to clk_in
//   mmcm_rst      MMCM RST drive, high only in RESET_MMCM
//   rst_out       system reset, high in every state except RUN
//   ready         high only in RUN (~rst_out)
//   relock_count  saturating count of lock losses while in RUN
//   timeout_count saturating count of WAIT_LOCK timeouts
//   state         FSM state: RESET_MMCM=0, WAIT_LOCK=1, STABLE=2, RUN=3
module mmcm_rst_ctrl #(
   parameter int LOCK_SYNC_STAGES     = 3,
   parameter int MMCM_RST_CYCLES      = 16,
   parameter int LOCK_TIMEOUT_CYCLES  = 65536,
   parameter int RELEASE_DELAY_CYCLES = 256,
   parameter int CNT_WIDTH            = 16
) (
   input  logic                 clk_in,
   input  logic                 rst_in,
   input  logic                 mmcm_lock,
   output logic                 mmcm_rst,
   output logic                 rst_out,
   output logic                 ready,
   output logic [CNT_WIDTH-1:0] relock_count,
   output logic [CNT_WIDTH-1:0] timeout_count,
   output logic [1:0]           state
);

   localparam logic [1:0] ST_RESET_MMCM = 2'd0;
   localparam logic [1:0] ST_WAIT_LOCK  = 2'd1;
   localparam logic [1:0] ST_STABLE     = 2'd2;
   localparam logic [1:0] ST_RUN        = 2'd3;

   // The shared cycle counter only has to reach the largest terminal count.
   localparam int MAX_A = (MMCM_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? MMCM_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
   localparam int MAX_C = (MAX_A > RELEASE_DELAY_CYCLES) ? MAX_A : RELEASE_DELAY_CYCLES;
   localparam int CW    = (MAX_C > 1) ? $clog2(MAX_C) : 1;

   localparam logic [CW-1:0] CNT_RST_LAST = CW'(MMCM_RST_CYCLES - 1);
   localparam logic [CW-1:0] CNT_TMO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CW-1:0] CNT_REL_LAST = CW'(RELEASE_DELAY_CYCLES - 1);

   logic [LOCK_SYNC_STAGES-1:0] sync_q;
   logic                        lock_s;
   logic [1:0]                  state_q, state_d;
   logic [CW-1:0]               cnt_q, cnt_d;
   logic [CNT_WIDTH-1:0]        relock_q, timeout_q;
   logic                        inc_relock, inc_timeout;
   logic                        mmcm_rst_q, rst_out_q;

   // Lock synchronizer: the only place mmcm_lock is sampled.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[LOCK_SYNC_STAGES-2:0], mmcm_lock};
      end
   end

   assign lock_s = sync_q[LOCK_SYNC_STAGES-1];

   always_comb begin
      state_d     = state_q;
      inc_relock  = 1'b0;
      inc_timeout = 1'b0;
      case (state_q)
         ST_RESET_MMCM: begin
            // lock_s is deliberately ignored while the MMCM is held in reset.
            if (cnt_q == CNT_RST_LAST) state_d = ST_WAIT_LOCK;
         end
         ST_WAIT_LOCK: begin
            // Lock takes priority over a coincident timeout.
            if (lock_s) begin
               state_d = ST_STABLE;
            end else if (cnt_q == CNT_TMO_LAST) begin
               state_d     = ST_RESET_MMCM;
               inc_timeout = 1'b1;
            end
         end
         ST_STABLE: begin
            // A glitch before release is not counted as a relock.
            if (!lock_s) begin
               state_d = ST_WAIT_LOCK;
            end else if (cnt_q == CNT_REL_LAST) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (!lock_s) begin
               state_d    = ST_RESET_MMCM;
               inc_relock = 1'b1;
            end
         end
         default: state_d = ST_RESET_MMCM;
      endcase
      // Counter restarts from zero on every state entry.
      cnt_d = (state_d != state_q) ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q    <= ST_RESET_MMCM;
         cnt_q      <= '0;
         mmcm_rst_q <= 1'b1;
         rst_out_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         // Outputs registered from the next state so they switch on the
         // same edge as the state register and are glitch-free.
         mmcm_rst_q <= (state_d == ST_RESET_MMCM);
         rst_out_q  <= (state_d != ST_RUN);
      end
   end

   // Saturating status counters, cleared only by rst_in.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         relock_q  <= '0;
         timeout_q <= '0;
      end else begin
         if (inc_relock && (relock_q != '1)) relock_q <= relock_q + CNT_WIDTH'(1);
         if (inc_timeout && (timeout_q != '1)) timeout_q <= timeout_q + CNT_WIDTH'(1);
      end
   end

   assign mmcm_rst      = mmcm_rst_q;
   assign rst_out       = rst_out_q;
   assign ready         = ~rst_out_q;
   assign relock_count  = relock_q;
   assign timeout_count = timeout_q;
   assign state         = state_q;

endmodule

// File: tb/tb_mmcm_rst_ctrl.sv
// Purpose : self-checking bench for mmcm_rst_ctrl; expected FSM transitions queued with stimulus.
// Latency : each expected transition carries the exact clk_in edge it must occur on.
// Backpress: n/a; stimulus is time-scheduled, every phase has a fixed cycle budget.
module tb_mmcm_rst_ctrl;

   localparam int SYNC = 2;
   localparam int RSTC = 4;
   localparam int TMO  = 32;
   localparam int REL  = 8;
   localparam int CW   = 4;

   logic          clk_in = 1'b0;
   logic          rst_in = 1'b1;
   logic          mmcm_lock = 1'b0;
   logic          mmcm_rst;
   logic          rst_out;
   logic          ready;
   logic [CW-1:0] relock_count;
   logic [CW-1:0] timeout_count;
   logic [1:0]    state;

   mmcm_rst_ctrl #(
      .LOCK_SYNC_STAGES     (SYNC),
      .MMCM_RST_CYCLES      (RSTC),
      .LOCK_TIMEOUT_CYCLES  (TMO),
      .RELEASE_DELAY_CYCLES (REL),
      .CNT_WIDTH            (CW)
   ) dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .mmcm_lock     (mmcm_lock),
      .mmcm_rst      (mmcm_rst),
      .rst_out       (rst_out),
      .ready         (ready),
      .relock_count  (relock_count),
      .timeout_count (timeout_count),
      .state         (state)
   );

   always #5 clk_in = ~clk_in;

   typedef struct {
      int st;
      int cyc;
      int rl;
      int tm;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_err    = 0;
   int   cyc      = 0;
   int   exp_relock = 0;
   int   exp_tmo    = 0;

   task automatic check_eq(input string tag, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic push_exp(input int st, input int at);
      exp_t e;
      e.st  = st;
      e.cyc = at;
      e.rl  = exp_relock;
      e.tm  = exp_tmo;
      exp_q.push_back(e);
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk_in);
         #1;
      end
   endtask

   // Assert rst_in just after an edge, check the asynchronous reset values,
   // hold for 'hold' cycles and release; e returns the edge of release.
   task automatic do_reset(input int hold, output int e);
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      #1;
      check_eq("rst_state", state, 0);
      check_eq("rst_mmcm_rst", mmcm_rst, 1);
      check_eq("rst_rst_out", rst_out, 1);
      check_eq("rst_ready", ready, 0);
      check_eq("rst_relock", relock_count, 0);
      check_eq("rst_timeout", timeout_count, 0);
      exp_relock = 0;
      exp_tmo    = 0;
      repeat (hold) begin
         @(posedge clk_in);
         #1;
      end
      rst_in = 1'b0;
      e = cyc;
   endtask

   initial forever begin
      @(posedge clk_in);
      cyc = cyc + 1;
   end

   // Monitor: every state change seen outside reset pops one expectation.
   initial begin
      int   prev;
      exp_t e;
      prev = 0;
      forever begin
         @(negedge clk_in);
         if (rst_in) begin
            prev = 0;
         end else if (int'(state) != prev) begin
            check_eq("trans_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check_eq("state", state, e.st);
               check_eq("trans_cycle", cyc, e.cyc);
               check_eq("mmcm_rst", mmcm_rst, int'(e.st == 0));
               check_eq("rst_out", rst_out, int'(e.st != 3));
               check_eq("ready", ready, int'(e.st == 3));
               check_eq("relock_count", relock_count, e.rl);
               check_eq("timeout_count", timeout_count, e.tm);
            end
            prev = int'(state);
         end
      end
   end

   initial begin
      int e, w, l, d;

      // Power-up with lock tied low: repeated timeouts, counter saturates at 15.
      do_reset(2, e);
      w = e + RSTC;
      push_exp(1, w);
      for (int k = 1; k <= 17; k++) begin
         if (exp_tmo < 15) exp_tmo++;
         push_exp(0, w + TMO);
         push_exp(1, w + TMO + RSTC);
         w = w + TMO + RSTC;
      end
      wait_until(w + 10);

      // Lock 10 cycles after mmcm_rst falls: straight through to RUN.
      do_reset(2, e);
      w = e + RSTC;
      push_exp(1, w);
      wait_until(w + 10);
      mmcm_lock = 1'b1;
      l = cyc;
      push_exp(2, l + SYNC + 1);
      push_exp(3, l + SYNC + 1 + REL);
      wait_until(l + 20);

      // Lock loss in RUN: 4-cycle mmcm_rst pulse, relock_count=1.
      mmcm_lock = 1'b0;
      d = cyc;
      exp_relock++;
      push_exp(0, d + SYNC + 1);
      push_exp(1, d + SYNC + 1 + RSTC);
      wait_until(d + 17);
      mmcm_lock = 1'b1;
      l = cyc;
      push_exp(2, l + 3);
      // 3-cycle glitch during STABLE: back to WAIT_LOCK, release delay restarts.
      wait_until(l + 5);
      mmcm_lock = 1'b0;
      push_exp(1, l + 8);
      wait_until(l + 8);
      mmcm_lock = 1'b1;
      push_exp(2, l + 11);
      push_exp(3, l + 11 + REL);
      wait_until(l + 25);

      // Lock one cycle too late: timeout wins, then lock is taken after re-reset.
      mmcm_lock = 1'b0;
      d = cyc;
      exp_relock++;
      push_exp(0, d + 3);
      w = d + 3 + RSTC;
      push_exp(1, w);
      wait_until(w + 30);
      mmcm_lock = 1'b1;
      exp_tmo++;
      push_exp(0, w + TMO);
      push_exp(1, w + TMO + RSTC);
      push_exp(2, w + TMO + RSTC + 1);
      push_exp(3, w + TMO + RSTC + 1 + REL);
      wait_until(w + 50);

      // Lock seen exactly when cnt reaches 31: STABLE, no timeout counted.
      mmcm_lock = 1'b0;
      d = cyc;
      exp_relock++;
      push_exp(0, d + 3);
      w = d + 3 + RSTC;
      push_exp(1, w);
      wait_until(w + 29);
      mmcm_lock = 1'b1;
      push_exp(2, w + TMO);
      push_exp(3, w + TMO + REL);
      wait_until(w + 45);

      // One-cycle rst_in pulse in RUN: counters cleared, full restart.
      do_reset(1, e);
      push_exp(1, e + RSTC);
      push_exp(2, e + RSTC + 1);
      push_exp(3, e + RSTC + 1 + REL);
      wait_until(e + 20);

      check_eq("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
